warp_mem_responder: RTL and testbench
=====================================

Name: warp_mem_responder

Overview:
- Memory-side responder for the warp engine's memory port. It accepts load/store requests from the engine and services them from an internal word-addressed scratchpad.
- It returns load data in order, after a fixed, parameterised latency, on a response channel that has no ready signal.
- Used as the engine's backing memory in subsystem simulation and small FPGA builds. It sits directly opposite the engine's mem_req_* / mem_resp_* pins.

Parameters:
- ADDR_WIDTH, 32, byte address width of mem_req_addr.
- DATA_WIDTH, 32, data word width; only 32 is supported.
- DEPTH, 1024, scratchpad size in words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.
- LATENCY, 2, cycles from read acceptance to response; legal range 1..8.
- ERR_DATA, 32'hDEAD_BEEF, data returned for an erroring read.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req_valid  in  1  request valid
- mem_req_ready  out  1  request accepted when valid && ready at rising edge
- mem_req_addr  in  ADDR_WIDTH  byte address
- mem_req_write  in  1  1 = store, 0 = load
- mem_req_data  in  32  store data
- mem_resp_valid  out  1  load data valid; one-cycle pulse per load, no backpressure
- mem_resp_data  out  32  load data
- err_count  out  16  saturating count of erroring requests
- busy  out  1  any load in flight in the response pipeline

Behaviour:
- Reset and ready:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n = 0: mem_req_ready = 0, mem_resp_valid = 0, mem_resp_data = 0, err_count = 0, busy = 0, all pipeline valid bits cleared.
  - mem_req_ready is registered. It rises on the first clock edge after rst_n deasserts, then stays high (absent the optional feature).
- Address decode (offset = addr - BASE_ADDR, ADDR_WIDTH-bit wrap):
  - Error if addr[1:0] != 0, or offset >= DEPTH*4.
  - Otherwise index = offset[2 +: log2(DEPTH)].
- Stores:
  - A store accepted in cycle N writes the word at the edge ending cycle N.
  - No response is generated.
  - An erroring store is dropped and increments err_count.
- Loads:
  - A load accepted in cycle N samples the array with write-before-read visibility: it sees every store accepted in cycles < N.
  - mem_resp_valid is high for exactly cycle N+LATENCY, with that data.
  - An erroring load still responds at N+LATENCY with ERR_DATA, and increments err_count.
- Throughput: one request per cycle. The LATENCY-stage shift pipeline holds valid+data. Responses are strictly in acceptance order; back-to-back loads give back-to-back response pulses.
- Response data: mem_resp_data holds its last value when mem_resp_valid = 0.
- err_count: saturates at 16'hFFFF and never wraps.
- busy: OR of all pipeline valid bits.
- Scratchpad: contents are not cleared by reset and are undefined after power-up.
- Reset mid-operation: in-flight loads are discarded and produce no response. Scratchpad writes already committed are retained.
- Requests presented while mem_req_ready = 0 are ignored. The requester must hold them; the block does not check stability.

Optional Feature:
- Macro: WARP_MEM_BACKPRESSURE_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, advancing every cycle after reset.
  - Registered mem_req_ready = 0 in any cycle where lfsr[1:0] == 2'b00, giving about 25% stall.
  - Latency from acceptance is unchanged.
- Not defined: no LFSR; mem_req_ready is constant 1 after reset release.

Test Plan:
- Reset release; store 32'h1234_5678 to 0x40, then load 0x40 the next cycle (LATENCY = 2, load accepted in cycle 5) -> mem_resp_valid only in cycle 7, data 32'h1234_5678, err_count = 0.
- Four back-to-back loads of 0x0, 0x4, 0x8, 0xC after storing 1, 2, 3, 4 -> four consecutive response pulses with 1, 2, 3, 4 in order; busy high throughout, low the cycle after the last pulse.
- Load 0x2 (misaligned), then load BASE_ADDR + DEPTH*4 -> two responses with 32'hDEAD_BEEF; err_count = 2. Store to 0x1001 -> no response; err_count = 3; array unchanged.
- Force err_count to 16'hFFFE, issue 3 erroring stores -> err_count holds at 16'hFFFF.
- Issue a load, assert rst_n low one cycle later -> no mem_resp_valid pulse ever. After release, load of the earlier-stored address returns the stored value.
- With WARP_MEM_BACKPRESSURE_EN: hold mem_req_valid high with 100 loads -> ready pattern matches the reference LFSR model from seed 16'hACE1; every accepted load responds exactly LATENCY cycles after acceptance.

Source files
------------

// File: rtl/warp_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : warp_mem_responder
//  Description : Memory-side responder for the warp engine memory port.
//                Services load/store requests from an internal word-addressed
//                scratchpad and returns load data in order after a fixed
//                LATENCY on a response channel without backpressure.
//                Optional build macro WARP_MEM_BACKPRESSURE_EN adds an
//                LFSR-driven stall pattern on mem_req_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module warp_mem_responder #(
    parameter int                     ADDR_WIDTH = 32,
    parameter int                     DATA_WIDTH = 32,
    parameter int                     DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter int                     LATENCY    = 2,
    parameter logic [DATA_WIDTH-1:0]  ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_write,
    input  logic [DATA_WIDTH-1:0] mem_req_data,
    output logic                  mem_resp_valid,
    output logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic [15:0]           err_count,
    output logic                  busy
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic                  r_ready;
    logic [15:0]           r_err_count;
    logic [LATENCY-1:0]    r_pipe_vld;
    logic [DATA_WIDTH-1:0] r_pipe_data [LATENCY];
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_err;
    logic [c_IDX_W-1:0]    w_index;
    logic                  w_load;
    logic                  w_store;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Decode: BASE_ADDR is DEPTH*4 aligned, so offset[1:0] equals addr[1:0]
    assign w_accept = mem_req_valid & r_ready;
    assign w_offset = mem_req_addr - BASE_ADDR;
    assign w_err    = (|w_offset[1:0]) | (|w_offset[ADDR_WIDTH-1:c_IDX_W+2]);
    assign w_index  = w_offset[2 +: c_IDX_W];
    assign w_load   = w_accept & ~mem_req_write;
    assign w_store  = w_accept & mem_req_write & ~w_err;
    // Array read sees all stores of earlier cycles; same-cycle store is impossible
    assign w_rdata  = w_err ? ERR_DATA : r_mem[w_index];

    // Scratchpad write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_index] <= mem_req_data;
        end
    end

    // Response pipeline; each stage data only moves with its valid so the
    // final stage holds the last response while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_data[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_load;
            if (w_load) begin
                r_pipe_data[0] <= w_rdata;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) begin
                    r_pipe_data[i] <= r_pipe_data[i-1];
                end
            end
        end
    end

    // Saturating count of accepted requests that failed decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && w_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

`ifdef WARP_MEM_BACKPRESSURE_EN
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    // Fibonacci LFSR, taps 16,14,13,11
    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    // Ready tracks the LFSR value it is registered alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr  <= c_LFSR_SEED;
            r_ready <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_ready <= |w_lfsr_next[1:0];
        end
    end
`else
    // Ready rises on the first edge after reset release and stays high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end
`endif

    assign mem_req_ready  = r_ready;
    assign mem_resp_valid = r_pipe_vld[LATENCY-1];
    assign mem_resp_data  = r_pipe_data[LATENCY-1];
    assign err_count      = r_err_count;
    assign busy           = |r_pipe_vld;

endmodule
`default_nettype wire

// File: tb/tb_warp_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_warp_mem_responder
//  Description : Self-checking bench for warp_mem_responder. Directed steps
//                followed by random load/store traffic, compared each cycle
//                against a transaction-level model (word map + timed queue).
//                Honours WARP_MEM_BACKPRESSURE_EN for the ready pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_warp_mem_responder;

    localparam int          c_LAT   = 2;
    localparam int          c_DEPTH = 1024;
    localparam logic [31:0] c_BASE  = 32'h0000_0000;
    localparam logic [31:0] c_ERR   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid = 1'b0;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr = '0;
    logic        mem_req_write = 1'b0;
    logic [31:0] mem_req_data = '0;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [15:0] err_count;
    logic        busy;

    warp_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(c_DEPTH),
        .BASE_ADDR(c_BASE), .LATENCY(c_LAT), .ERR_DATA(c_ERR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
        .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    // Reference model state
    logic [31:0] model_mem [int];
    resp_t       exp_q [$];
    logic [31:0] last_data = '0;
    logic [15:0] err_m = '0;
    logic        exp_ready = 1'b0;
    logic [15:0] lfsr_m = 16'hACE1;
    int          cyc = 0;
    logic        acc = 1'b0;

    int checks = 0;
    int passed = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        // Feedback is the XOR of tap positions 16,14,13,11 (bits 0,2,3,5)
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One clock cycle: compare outputs mid-cycle, apply model, advance
    task automatic tick();
        logic [31:0] off;
        logic        err;
        logic        exp_busy;
        @(negedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            chk("rst_ready", {31'd0, mem_req_ready}, 32'd0);
            chk("rst_valid", {31'd0, mem_resp_valid}, 32'd0);
            chk("rst_data", mem_resp_data, 32'd0);
            chk("rst_err", {16'd0, err_count}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            exp_q.delete();
            last_data = '0;
            err_m     = '0;
            exp_ready = 1'b0;
        end else begin
            exp_busy = (exp_q.size() != 0);
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                chk("resp_valid", {31'd0, mem_resp_valid}, 32'd1);
                chk("resp_data", mem_resp_data, exp_q[0].data);
                last_data = exp_q[0].data;
                void'(exp_q.pop_front());
            end else begin
                chk("resp_idle", {31'd0, mem_resp_valid}, 32'd0);
                chk("resp_hold", mem_resp_data, last_data);
            end
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("err_count", {16'd0, err_count}, {16'd0, err_m});
            chk("ready", {31'd0, mem_req_ready}, {31'd0, exp_ready});
            if (mem_req_valid && exp_ready) begin
                acc = 1'b1;
                off = mem_req_addr - c_BASE;
                err = (mem_req_addr % 4 != 0) || (off >= c_DEPTH * 4);
                if (err && err_m != 16'hFFFF) err_m = err_m + 16'd1;
                if (!mem_req_write) begin
                    exp_q.push_back('{due: cyc + c_LAT,
                                      data: err ? c_ERR : model_mem[int'(off / 4)]});
                end else if (!err) begin
                    model_mem[int'(off / 4)] = mem_req_data;
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            exp_ready = 1'b0;
            lfsr_m    = 16'hACE1;
        end else begin
`ifdef WARP_MEM_BACKPRESSURE_EN
            lfsr_m    = lfsr_step(lfsr_m);
            exp_ready = (lfsr_m % 4 != 0);
`else
            exp_ready = 1'b1;
`endif
        end
        #1;
    endtask

    // Present a request and hold it until accepted (bounded)
    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
        int k;
        mem_req_valid = 1'b1;
        mem_req_write = w;
        mem_req_addr  = a;
        mem_req_data  = d;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 64) begin
            tick();
            k++;
        end
        checks++;
        assert (acc) passed++;
        else $error("FAIL req_accept: observed not accepted expected accepted addr %h", a);
    endtask

    task automatic idle(input int n);
        mem_req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset, then present an erroring store while ready is still low
        rst_n = 1'b0;
        idle(3);
        rst_n         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = 32'h0000_1001;
        tick();
        idle(2);

        // Store then load the next cycle
        req(1'b1, 32'h40, 32'h1234_5678);
        req(1'b0, 32'h40, 32'h0);
        idle(4);

        // Back-to-back stores and loads
        for (int i = 0; i < 4; i++) req(1'b1, 32'(i * 4), 32'(i + 1));
        for (int i = 0; i < 4; i++) req(1'b0, 32'(i * 4), 32'h0);
        idle(5);

        // Misaligned and out-of-range loads, erroring store, then word 0 intact
        req(1'b0, 32'h2, 32'h0);
        req(1'b0, c_BASE + c_DEPTH * 4, 32'h0);
        req(1'b1, 32'h1001, 32'hFFFF_0000);
        idle(4);
        req(1'b0, 32'h0, 32'h0);
        idle(4);

        // err_count saturation
        force dut.r_err_count = 16'hFFFE;
        #1;
        release dut.r_err_count;
        err_m = 16'hFFFE;
        for (int i = 0; i < 3; i++) req(1'b1, 32'h3, 32'h0);
        idle(3);

        // Reset one cycle after a load is accepted: response is discarded
        req(1'b0, 32'h40, 32'h0);
        mem_req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req(1'b0, 32'h40, 32'h0);
        idle(5);

        // Random traffic over a pre-initialised window of 32 words
        for (int i = 0; i < 32; i++) req(1'b1, 32'(i * 4), $urandom);
        for (int n = 0; n < 300; n++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                mem_req_valid = 1'b0;
                mem_req_write = 1'($urandom);
                mem_req_addr  = $urandom;
                mem_req_data  = $urandom;
                tick();
            end else begin
                a = 32'($urandom_range(0, 31) * 4);
                if ($urandom_range(0, 9) == 0) begin
                    a = ($urandom_range(0, 1) == 0) ? (a | 32'($urandom_range(1, 3)))
                                                    : (a + c_DEPTH * 4);
                end
                req(1'($urandom), a, $urandom);
            end
        end
        idle(c_LAT + 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
